// File: rtl/univ_piposr_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst FSM states, shift function.
// Latency: n/a (types and a pure combinational function).
// Backpressure: none.
package univ_piposr_pkg;

    // Widest register the shared shift function supports
    localparam int MAXW = 32;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_SHR  = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_ROR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ASR  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // One shift step on the low w bits of sr; bits at w and above come back as zero.
    // Codes 6 and 7 fall through to hold.
    function automatic logic [MAXW-1:0] next_sr(input logic [MAXW-1:0] sr,
                                                 input logic [2:0]      mode,
                                                 input logic            sir,
                                                 input logic            sil,
                                                 input int              w);
        logic [MAXW-1:0] r;
        logic            msb;
        msb = sr[w-1];
        case (mode)
            M_SHR:   begin r = sr >> 1; r[w-1] = sir;   end
            M_SHL:   r = {sr[MAXW-2:0], sil};
            M_ROR:   begin r = sr >> 1; r[w-1] = sr[0]; end
            M_ROL:   r = {sr[MAXW-2:0], msb};
            M_ASR:   begin r = sr >> 1; r[w-1] = msb;   end
            default: r = sr;
        endcase
        for (int i = 0; i < MAXW; i++) begin
            if (i >= w) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/piposr_burst_ctrl.sv
// Burst controller: IDLE/RUN/FIN FSM, remaining-shift count and latched burst mode.
// Latency: START at edge t runs shifts at edges t+1..t+n; DONE is high for the cycle after edge t+n.
// Backpressure: none; LDin, MODE and START are ignored while a burst runs or finishes.
module piposr_burst_ctrl
    import univ_piposr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          i_ck,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_ld,
    input  logic [2:0]    i_mode,
    input  logic [CW-1:0] i_cnt,
    output logic          o_busy,
    output logic          o_done,
    output logic [2:0]    o_mode,
    output logic          o_ld_en
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_rem_nxt;
    logic [2:0]    r_bmode;
    logic [2:0]    w_bmode_nxt;
    logic [CW-1:0] w_cnt_sat;

    // Over-long requests are clamped so a burst never exceeds one full register width
    assign w_cnt_sat = (i_cnt > CNT_MAX) ? CNT_MAX : i_cnt;

    // State, remaining count and latched mode registers
    always_ff @(posedge i_ck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_bmode <= M_HOLD;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_bmode <= w_bmode_nxt;
        end
    end

    // Next-state logic and the mode/load selection seen by the shift register
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_bmode_nxt = r_bmode;
        o_mode      = M_HOLD;
        o_ld_en     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A load on the same edge as START wins and the START is dropped
                o_ld_en = i_ld;
                if (!i_ld) begin
                    if (i_start) begin
                        // The START edge itself leaves SR untouched
                        w_rem_nxt   = w_cnt_sat;
                        w_bmode_nxt = i_mode;
                        w_state_nxt = (w_cnt_sat == '0) ? S_FIN : S_RUN;
                    end else begin
                        o_mode = i_mode;
                    end
                end
            end
            S_RUN: begin
                o_busy    = 1'b1;
                o_mode    = r_bmode;
                w_rem_nxt = r_rem - CW'(1);
                if (r_rem == CW'(1)) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/univ_piposr.sv
// Universal parallel-in/parallel-out shift register with shift/rotate modes and counted auto-shift bursts.
// Latency: Din reaches the serial taps 1 edge after LDin and Dout 2 edges after LDin (LDout on the second edge).
// Backpressure: none; BUSY flags that parallel load and MODE are ignored during a burst.
module univ_piposr
    import univ_piposr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Din,
    input  logic             LDin,
    input  logic             LDout,
    input  logic [2:0]       MODE,
    input  logic             SIR,
    input  logic             SIL,
    input  logic             START,
    input  logic [CW-1:0]    CNT,
    output logic [WIDTH-1:0] Dout,
    output logic             SOR,
    output logic             SOL,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [2:0]       w_eff_mode;
    logic             w_ld_en;

    piposr_burst_ctrl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctrl (
        .i_ck    (CK),
        .i_rst   (RST),
        .i_start (START),
        .i_ld    (LDin),
        .i_mode  (MODE),
        .i_cnt   (CNT),
        .o_busy  (BUSY),
        .o_done  (DONE),
        .o_mode  (w_eff_mode),
        .o_ld_en (w_ld_en)
    );

    // Free-running and burst shifts share one datapath; the controller chooses the mode
    assign w_sr_nxt = WIDTH'(next_sr(MAXW'(r_sr), w_eff_mode, SIR, SIL, WIDTH));

    // Shift register: parallel load has priority over the selected shift
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_sr <= '0;
        end else if (w_ld_en) begin
            r_sr <= Din;
        end else begin
            r_sr <= w_sr_nxt;
        end
    end

    // Output register captures SR as it was before this edge's update
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_dout <= '0;
        end else if (LDout) begin
            r_dout <= r_sr;
        end
    end

    assign Dout = r_dout;
    assign SOR  = r_sr[0];
    assign SOL  = r_sr[WIDTH-1];

endmodule

// File: tb/tb_univ_piposr.sv
// Bench for univ_piposr (WIDTH = 8) with a behavioural reference model feeding a scoreboard.
// Latency: expectations pushed at each rising CK, compared 90 ns later.
// Backpressure: n/a.
module tb_univ_piposr;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         CK    = 1'b0;
    logic         RST   = 1'b1;
    logic [W-1:0] Din   = '0;
    logic         LDin  = 1'b0;
    logic         LDout = 1'b0;
    logic [2:0]   MODE  = 3'd0;
    logic         SIR   = 1'b0;
    logic         SIL   = 1'b0;
    logic         START = 1'b0;
    logic [CW-1:0] CNT  = '0;
    wire  [W-1:0] Dout;
    wire          SOR;
    wire          SOL;
    wire          BUSY;
    wire          DONE;

    univ_piposr #(.WIDTH(W), .CW(CW)) dut (
        .CK    (CK),
        .RST   (RST),
        .Din   (Din),
        .LDin  (LDin),
        .LDout (LDout),
        .MODE  (MODE),
        .SIR   (SIR),
        .SIL   (SIL),
        .START (START),
        .CNT   (CNT),
        .Dout  (Dout),
        .SOR   (SOR),
        .SOL   (SOL),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial forever #50 CK = ~CK;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         sor;
        logic         sol;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state 0 idle, 1 burst running, 2 burst finished
    logic [W-1:0] m_sr;
    logic [W-1:0] m_dout;
    logic [W-1:0] m_old;
    logic [2:0]   m_bmode;
    int           m_st;
    int           m_rem;
    int           m_n;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] s, input logic [2:0] m,
                                            input logic sir, input logic sil);
        case (m)
            3'd1:    return {sir, s[W-1:1]};
            3'd2:    return {s[W-2:0], sil};
            3'd3:    return {s[0], s[W-1:1]};
            3'd4:    return {s[W-2:0], s[W-1]};
            3'd5:    return {s[W-1], s[W-1:1]};
            default: return s;
        endcase
    endfunction

    function automatic exp_t m_out(input logic [W-1:0] sr, input logic [W-1:0] dout, input int st);
        exp_t e;
        e.dout = dout;
        e.sor  = sr[0];
        e.sol  = sr[W-1];
        e.busy = (st == 1);
        e.done = (st == 2);
        return e;
    endfunction

    initial begin
        m_sr = '0; m_dout = '0; m_old = '0; m_bmode = '0; m_st = 0; m_rem = 0; m_n = 0;
        forever begin
            @(posedge CK or posedge RST);
            if (RST) begin
                m_sr = '0; m_dout = '0; m_st = 0; m_rem = 0; m_bmode = '0;
                if (CK) begin
                    q.push_back(m_out(m_sr, m_dout, m_st));
                end else begin
                    // Asynchronous reset: pending expectations now see the cleared outputs
                    m_n = q.size();
                    q.delete();
                    repeat (m_n) q.push_back(m_out(m_sr, m_dout, m_st));
                end
            end else begin
                m_old = m_sr;
                if (LDout) m_dout = m_old;
                case (m_st)
                    0: begin
                        if (LDin) m_sr = Din;
                        else if (START) begin
                            m_n = (int'(CNT) > W) ? W : int'(CNT);
                            if (m_n == 0) m_st = 2;
                            else begin
                                m_st = 1; m_rem = m_n; m_bmode = MODE;
                            end
                        end else m_sr = ref_op(m_sr, MODE, SIR, SIL);
                    end
                    1: begin
                        m_sr = ref_op(m_sr, m_bmode, SIR, SIL);
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_st = 2;
                    end
                    default: m_st = 0;
                endcase
                q.push_back(m_out(m_sr, m_dout, m_st));
            end
        end
    end

    // Scoreboard: one expectation per rising edge, checked 90 ns later
    initial begin
        exp_t e;
        forever begin
            @(posedge CK);
            #90;
            chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_dout", 32'(Dout), 32'(e.dout));
                chk("sb_sor",  32'(SOR),  32'(e.sor));
                chk("sb_sol",  32'(SOL),  32'(e.sol));
                chk("sb_busy", 32'(BUSY), 32'(e.busy));
                chk("sb_done", 32'(DONE), 32'(e.done));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CK);
        #20;
    endtask

    task automatic load(input logic [W-1:0] d);
        LDin = 1'b1; Din = d;
        tick();
        LDin = 1'b0;
    endtask

    task automatic copy_chk(input string tag, input logic [W-1:0] exp);
        LDout = 1'b1;
        tick();
        LDout = 1'b0;
        chk(tag, 32'(Dout), 32'(exp));
    endtask

    task automatic async_rst(input string tag);
        #31 RST = 1'b1;
        #1;
        chk({tag, "_dout"}, 32'(Dout), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_sor"},  32'(SOR),  32'd0);
        chk({tag, "_sol"},  32'(SOL),  32'd0);
        #8 RST = 1'b0;
    endtask

    task automatic free_op(input string tag, input logic [2:0] m, input logic sir,
                           input logic sil, input logic [W-1:0] exp);
        load(8'h96);
        MODE = m; SIR = sir; SIL = sil;
        tick();
        MODE = 3'd0; SIR = 1'b0; SIL = 1'b0;
        copy_chk(tag, exp);
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;

        // Reset mid-cycle with SR = A5
        load(8'hA5);
        copy_chk("pre_rst_dout", 8'hA5);
        async_rst("rst");
        tick();
        tick();
        copy_chk("rst_idle_sr", 8'h00);

        // Load then copy
        load(8'h96);
        chk("ld_sol", 32'(SOL), 32'd1);
        chk("ld_sor", 32'(SOR), 32'd0);
        copy_chk("ld_dout", 8'h96);

        // Free-running single shifts from 96
        free_op("shr", 3'd1, 1'b1, 1'b0, 8'hCB);
        free_op("shl", 3'd2, 1'b0, 1'b0, 8'h2C);
        free_op("ror", 3'd3, 1'b0, 1'b0, 8'h4B);
        free_op("rol", 3'd4, 1'b0, 1'b0, 8'h2D);
        free_op("asr", 3'd5, 1'b0, 1'b0, 8'hCB);
        free_op("m6_hold", 3'd6, 1'b1, 1'b1, 8'h96);

        // Burst of 3 ROL from 81 with mid-burst load and MODE change
        load(8'h81);
        MODE = 3'd4; CNT = 4'd3; START = 1'b1;
        tick();
        START = 1'b0; LDin = 1'b1; Din = 8'hFF; MODE = 3'd0;
        chk("b_busy1", 32'(BUSY), 32'd1);
        tick();
        chk("b_busy2", 32'(BUSY), 32'd1);
        tick();
        chk("b_busy3", 32'(BUSY), 32'd1);
        tick();
        chk("b_done", 32'(DONE), 32'd1);
        chk("b_busy_off", 32'(BUSY), 32'd0);
        LDin = 1'b0;
        copy_chk("b_sr", 8'h0C);
        chk("b_done_off", 32'(DONE), 32'd0);

        // CNT = 0, with START held through the FIN cycle
        load(8'h5A);
        MODE = 3'd1; CNT = 4'd0; START = 1'b1;
        tick();
        MODE = 3'd0; CNT = 4'd2;
        chk("c0_done", 32'(DONE), 32'd1);
        chk("c0_busy", 32'(BUSY), 32'd0);
        tick();
        START = 1'b0;
        chk("fin_start_busy", 32'(BUSY), 32'd0);
        chk("fin_start_done", 32'(DONE), 32'd0);
        copy_chk("c0_sr", 8'h5A);

        // CNT = 15 clamps to a full 8-step rotation
        load(8'h3C);
        MODE = 3'd3; CNT = 4'd15; START = 1'b1;
        tick();
        START = 1'b0; MODE = 3'd0;
        chk("sat_busy_first", 32'(BUSY), 32'd1);
        for (int i = 1; i < 8; i++) tick();
        chk("sat_busy_last", 32'(BUSY), 32'd1);
        tick();
        chk("sat_done", 32'(DONE), 32'd1);
        copy_chk("sat_sr", 8'h3C);

        // START and LDin together: load wins
        LDin = 1'b1; Din = 8'hE7; START = 1'b1; CNT = 4'd2; MODE = 3'd1;
        tick();
        LDin = 1'b0; START = 1'b0; MODE = 3'd0;
        chk("sl_busy", 32'(BUSY), 32'd0);
        tick();
        chk("sl_done", 32'(DONE), 32'd0);
        copy_chk("sl_sr", 8'hE7);

        // Abort a 5-shift burst with reset during its second cycle
        load(8'h01);
        MODE = 3'd2; SIL = 1'b1; CNT = 4'd5; START = 1'b1;
        tick();
        START = 1'b0; MODE = 3'd0;
        chk("ab_busy", 32'(BUSY), 32'd1);
        tick();
        async_rst("ab");
        SIL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_no_done", 32'(DONE), 32'd0);
        end
        MODE = 3'd1; SIR = 1'b1; CNT = 4'd1; START = 1'b1;
        tick();
        START = 1'b0; MODE = 3'd0;
        chk("ab_new_busy", 32'(BUSY), 32'd1);
        tick();
        SIR = 1'b0;
        chk("ab_new_done", 32'(DONE), 32'd1);
        copy_chk("ab_new_sr", 8'h80);

        tick();
        @(posedge CK);
        #95;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
